// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and sequencer state encodings shared by the nibble ALU and its sequencer
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic is_logic_op(input logic [1:0] op);
        return (op == OP_AND) || (op == OP_OR);
    endfunction

endpackage

// File: rtl/alu_4bit.sv
// rtl/alu_4bit.sv - 4-bit combinational ALU slice; for SUB cin/cout are borrow-in/borrow-out
module alu_4bit
    import alu_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic [1:0] op_i,
    input  logic       cin_i,
    output logic [3:0] y_o,
    output logic       cout_o
);

    logic [4:0] sum;

    always_comb begin
        sum = 5'd0;
        case (op_i)
            OP_ADD:  sum = {1'b0, a_i} + {1'b0, b_i} + {4'd0, cin_i};
            // Bit 4 of the 5-bit difference is set exactly when a borrow was needed.
            OP_SUB:  sum = {1'b0, a_i} - {1'b0, b_i} - {4'd0, cin_i};
            OP_AND:  sum = {1'b0, a_i & b_i};
            default: sum = {1'b0, a_i | b_i};
        endcase
        y_o    = sum[3:0];
        cout_o = sum[4];
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - nibble-serial WIDTH-bit ADD/SUB/AND/OR over one alu_4bit
// Optional ovf_o signed-overflow output is enabled by defining ALU_SEQ_OVF_EN.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [1:0]           op_i,
    input  logic [4*NIBBLES-1:0] a_i,
    input  logic [4*NIBBLES-1:0] b_i,
    input  logic                 cin_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [4*NIBBLES-1:0] result_o,
    output logic                 cout_o,
    output logic                 zero_o
`ifdef ALU_SEQ_OVF_EN
   ,output logic                 ovf_o
`endif
);

    localparam int WIDTH = 4 * NIBBLES;

    logic [1:0]       state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d;
    logic [1:0]       op_q, op_d;
    logic             chain_q, chain_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d, zero_q, zero_d, ovf_q, ovf_d;

    logic [3:0]       alu_y;
    logic             alu_cout;
    logic [WIDTH-1:0] sh_next;
    logic             chain_next;

    alu_4bit u_alu (
        .a_i    (a_q[3:0]),
        .b_i    (b_q[3:0]),
        .op_i   (op_q),
        .cin_i  (chain_q),
        .y_o    (alu_y),
        .cout_o (alu_cout)
    );

    // Operands shift right so the active nibble is always [3:0]; results enter at the MSB side.
    assign sh_next    = WIDTH'({alu_y, sh_q} >> 4);
    assign chain_next = is_logic_op(op_q) ? 1'b0 : alu_cout;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        chain_d  = chain_q;
        sh_d     = sh_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    idx_d   = 3'd0;
                    a_d     = a_i;
                    b_d     = b_i;
                    op_d    = op_i;
                    chain_d = is_logic_op(op_i) ? 1'b0 : cin_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d     = WIDTH'({4'd0, a_q} >> 4);
                b_d     = WIDTH'({4'd0, b_q} >> 4);
                sh_d    = sh_next;
                chain_d = chain_next;
                idx_d   = idx_q + 3'd1;
                if (idx_q == 3'(NIBBLES - 1)) begin
                    state_d  = ST_DONE;
                    result_d = sh_next;
                    cout_d   = chain_next;
                    zero_d   = (sh_next == '0);
                    // The last nibble holds the sign bits of A, B and the result.
                    case (op_q)
                        OP_ADD:  ovf_d = (a_q[3] == b_q[3]) && (alu_y[3] != a_q[3]);
                        OP_SUB:  ovf_d = (a_q[3] != b_q[3]) && (alu_y[3] != a_q[3]);
                        default: ovf_d = 1'b0;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= 3'd0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_ADD;
            chain_q  <= 1'b0;
            sh_q     <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            chain_q  <= chain_d;
            sh_q     <= sh_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy_o   = (state_q == ST_RUN);
    assign done_o   = (state_q == ST_DONE);
    assign result_o = result_q;
    assign cout_o   = cout_q;
    assign zero_o   = zero_q;
`ifdef ALU_SEQ_OVF_EN
    assign ovf_o    = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - directed self-checking bench for alu_seq_ctrl (16-bit default)
module tb_alu_seq_ctrl;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [15:0] a_i = 16'h0;
    logic [15:0] b_i = 16'h0;
    logic        cin_i = 1'b0;
    logic        busy_o, done_o, cout_o, zero_o;
    logic [15:0] result_o;
`ifdef ALU_SEQ_OVF_EN
    logic        ovf_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    alu_seq_ctrl #(.NIBBLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .cin_i    (cin_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .cout_o   (cout_o),
        .zero_o   (zero_o)
`ifdef ALU_SEQ_OVF_EN
       ,.ovf_o    (ovf_o)
`endif
    );

    always #5 clk = ~clk;

    // Present a request at a negedge; it is accepted at the following posedge.
    task automatic start_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic cin);
        @(negedge clk);
        op_i = op; a_i = a; b_i = b; cin_i = cin; start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        a_i = 16'hDEAD; b_i = 16'hBEEF; op_i = 2'b11; cin_i = 1'b1;
    endtask

    // Counts negedges from the accepting edge until done_o is seen; lat=-1 on timeout.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = -1;
        busy_cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busy_o) busy_cnt++;
            if (done_o) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic check_op(input string name, input logic [15:0] exp_r, input logic exp_c,
                            input logic exp_z);
        int lat, bc;
        wait_done(lat, bc);
        n_cmp++;
        if (lat !== 5) begin n_bad++; $display("FAIL %s latency: got %0d want 5", name, lat); end
        n_cmp++;
        if (bc !== 4) begin n_bad++; $display("FAIL %s busy_cycles: got %0d want 4", name, bc); end
        n_cmp++;
        if (result_o !== exp_r) begin
            n_bad++; $display("FAIL %s result: got %h want %h", name, result_o, exp_r);
        end
        n_cmp++;
        if (cout_o !== exp_c) begin n_bad++; $display("FAIL %s cout: got %b want %b", name, cout_o, exp_c); end
        n_cmp++;
        if (zero_o !== exp_z) begin n_bad++; $display("FAIL %s zero: got %b want %b", name, zero_o, exp_z); end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #12;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy_o, done_o, result_o, cout_o, zero_o} !== 20'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b r=%h c=%b z=%b want all 0",
                     busy_o, done_o, result_o, cout_o, zero_o);
        end
`ifdef ALU_SEQ_OVF_EN
        n_cmp++;
        if (ovf_o !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf_o); end
`endif
    endtask

    task automatic test_add;
        start_op(OP_ADD, 16'h1234, 16'h0FFF, 1'b0);
        check_op("add_basic", 16'h2233, 1'b0, 1'b0);
`ifdef ALU_SEQ_OVF_EN
        n_cmp++;
        if (ovf_o !== 1'b0) begin n_bad++; $display("FAIL add_basic ovf: got %b want 0", ovf_o); end
`endif
        @(negedge clk);
        n_cmp++;
        if (done_o !== 1'b0) begin n_bad++; $display("FAIL done_pulse_width: got %b want 0", done_o); end
        start_op(OP_ADD, 16'hFFFF, 16'h0001, 1'b0);
        check_op("add_wrap", 16'h0000, 1'b1, 1'b1);
        start_op(OP_ADD, 16'h00FF, 16'h0000, 1'b1);
        check_op("add_cin", 16'h0100, 1'b0, 1'b0);
`ifdef ALU_SEQ_OVF_EN
        start_op(OP_ADD, 16'h7FFF, 16'h0001, 1'b0);
        check_op("add_ovf", 16'h8000, 1'b0, 1'b0);
        n_cmp++;
        if (ovf_o !== 1'b1) begin n_bad++; $display("FAIL add_ovf ovf: got %b want 1", ovf_o); end
`endif
    endtask

    task automatic test_sub;
        start_op(OP_SUB, 16'h1000, 16'h0001, 1'b0);
        check_op("sub_borrow_chain", 16'h0FFF, 1'b0, 1'b0);
        start_op(OP_SUB, 16'h0000, 16'h0001, 1'b0);
        check_op("sub_underflow", 16'hFFFF, 1'b1, 1'b0);
        start_op(OP_SUB, 16'h0005, 16'h0004, 1'b1);
        check_op("sub_bin", 16'h0000, 1'b0, 1'b1);
`ifdef ALU_SEQ_OVF_EN
        start_op(OP_SUB, 16'h8000, 16'h0001, 1'b0);
        check_op("sub_ovf", 16'h7FFF, 1'b0, 1'b0);
        n_cmp++;
        if (ovf_o !== 1'b1) begin n_bad++; $display("FAIL sub_ovf ovf: got %b want 1", ovf_o); end
`endif
    endtask

    task automatic test_logic;
        start_op(OP_AND, 16'hA5F0, 16'h0FFF, 1'b0);
        check_op("and", 16'h05F0, 1'b0, 1'b0);
        start_op(OP_OR, 16'hA000, 16'h0505, 1'b1);
        check_op("or_cin_ignored", 16'hA505, 1'b0, 1'b0);
        start_op(OP_AND, 16'hF0F0, 16'h0F0F, 1'b1);
        check_op("and_zero", 16'h0000, 1'b0, 1'b1);
    endtask

    task automatic test_ignore_start;
        logic [15:0] held;
        start_op(OP_ADD, 16'h1111, 16'h2222, 1'b0);
        held = result_o;
        @(negedge clk);
        start_i = 1'b1; a_i = 16'hFFFF; b_i = 16'hFFFF; op_i = OP_SUB;
        n_cmp++;
        if (result_o !== held) begin n_bad++; $display("FAIL result_stable_run: got %h want %h", result_o, held); end
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 10 && !done_o; i++) @(negedge clk);
        n_cmp++;
        if (result_o !== 16'h3333) begin
            n_bad++; $display("FAIL ignore_start result: got %h want 3333", result_o);
        end
        @(negedge clk);
        n_cmp++;
        if ({busy_o, done_o} !== 2'b00) begin
            n_bad++; $display("FAIL ignore_start no_queue: got busy=%b done=%b want 0 0", busy_o, done_o);
        end
    endtask

    task automatic test_back_to_back;
        start_op(OP_ADD, 16'h0001, 16'h0002, 1'b0);
        for (int i = 0; i < 10 && !done_o; i++) @(negedge clk);
        n_cmp++;
        if (result_o !== 16'h0003) begin n_bad++; $display("FAIL b2b first: got %h want 0003", result_o); end
        op_i = OP_OR; a_i = 16'h1200; b_i = 16'h0034; cin_i = 1'b0; start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        a_i = 16'h0; b_i = 16'h0;
        check_op("b2b_second", 16'h1234, 1'b0, 1'b0);
    endtask

    task automatic test_reset_abort;
        int seen;
        start_op(OP_ADD, 16'h4000, 16'h0001, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy_o, done_o, result_o} !== 18'h0) begin
            n_bad++;
            $display("FAIL async_abort: got busy=%b done=%b r=%h want 0 0 0000", busy_o, done_o, result_o);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done_o || busy_o) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d active cycles want 0", seen); end
        start_op(OP_SUB, 16'h0100, 16'h0001, 1'b0);
        check_op("after_abort", 16'h00FF, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
